// File: rtl/uart_word_receiver_if.sv
// Word hand-off bundle between the UART word receiver and its consumer.
// The master drives the word and its valid flag. The slave drives ready.
interface uart_word_receiver_if;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word;

  modport master (output word_valid, output word, input word_ready);
  modport slave  (input word_valid, input word, output word_ready);
endinterface

// File: rtl/uart_word_receiver.sv
// 8N1 UART receiver with 16x oversampling. It packs four bytes, little-endian,
// into a 32-bit word offered on a valid/ready port, and keeps sticky error flags.
module uart_word_receiver #(
  parameter int unsigned OVERSAMPLE_DIV = 54,
  parameter int unsigned TIMEOUT_BITS   = 64
) (
  input  logic                        iFpgaClock,
  input  logic                        iCpuReset,
  input  logic                        iUartRx,
  output logic                        oByteValid,
  output logic [7:0]                  oByte,
  uart_word_receiver_if.master        word_bus,
  output logic                        oFramingError,
  output logic                        oOverrun,
  output logic                        oPartialDropped,
  input  logic                        iClearErrors,
  output logic                        oBusy
);
  localparam int unsigned DIV_W    = (OVERSAMPLE_DIV > 1) ? $clog2(OVERSAMPLE_DIV) : 1;
  localparam int unsigned TO_TICKS = TIMEOUT_BITS * 16;
  localparam int unsigned TO_W     = $clog2(TO_TICKS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OVERSAMPLE_DIV - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_TICKS - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

  state_t            state;
  logic              rx_meta, rxs;
  logic [DIV_W-1:0]  div_cnt;
  logic              tick;
  logic [3:0]        s;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift;
  logic [1:0]        index;
  logic [7:0]        slot0, slot1, slot2;
  logic [TO_W-1:0]   to_cnt;

  assign tick  = (div_cnt == DIV_LAST);
  assign oBusy = (state != IDLE);

  // Synchronizer resets to the idle level so a reset never looks like a start bit.
  always_ff @(posedge iFpgaClock) begin
    if (!iCpuReset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      div_cnt <= '0;
    end else begin
      rx_meta <= iUartRx;
      rxs     <= rx_meta;
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
    end
  end

  always_ff @(posedge iFpgaClock) begin
    if (!iCpuReset) begin
      state               <= IDLE;
      s                   <= '0;
      bit_cnt             <= '0;
      shift               <= '0;
      index               <= '0;
      slot0               <= '0;
      slot1               <= '0;
      slot2               <= '0;
      to_cnt              <= '0;
      oByteValid          <= 1'b0;
      oByte               <= '0;
      word_bus.word_valid <= 1'b0;
      word_bus.word       <= '0;
      oFramingError       <= 1'b0;
      oOverrun            <= 1'b0;
      oPartialDropped     <= 1'b0;
    end else begin
      oByteValid <= 1'b0;
      // Clear first so that a set event later in this block wins.
      if (iClearErrors) begin
        oFramingError   <= 1'b0;
        oOverrun        <= 1'b0;
        oPartialDropped <= 1'b0;
      end
      if (word_bus.word_valid && word_bus.word_ready)
        word_bus.word_valid <= 1'b0;

      case (state)
        IDLE: if (!rxs) begin
          s     <= '0;
          state <= START;
        end
        START: if (tick) begin
          if (s == 4'd7) begin
            s       <= '0;
            bit_cnt <= '0;
            state   <= rxs ? IDLE : DATA;
          end else begin
            s <= s + 4'd1;
          end
        end
        DATA: if (tick) begin
          s <= s + 4'd1;
          if (s == 4'd15) begin
            shift   <= {rxs, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= STOP;
          end
        end
        STOP: if (tick) begin
          s <= s + 4'd1;
          if (s == 4'd15) begin
            if (rxs) begin
              oByte      <= shift;
              oByteValid <= 1'b1;
              index      <= index + 2'd1;
              case (index)
                2'd0: slot0 <= shift;
                2'd1: slot1 <= shift;
                2'd2: slot2 <= shift;
                default: begin
                  if (!word_bus.word_valid || word_bus.word_ready) begin
                    word_bus.word       <= {shift, slot2, slot1, slot0};
                    word_bus.word_valid <= 1'b1;
                  end else begin
                    oOverrun <= 1'b1;
                  end
                end
              endcase
              state <= IDLE;
            end else begin
              oFramingError <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end
        end
        WAIT_HIGH: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase

      // Partial-word timeout only runs between frames, so it never competes with a byte accept.
      if (index == 2'd0 || (state == IDLE && !rxs)) begin
        to_cnt <= '0;
      end else if (state == IDLE && tick) begin
        if (to_cnt == TO_LAST) begin
          to_cnt          <= '0;
          index           <= '0;
          slot0           <= '0;
          slot1           <= '0;
          slot2           <= '0;
          oPartialDropped <= 1'b1;
        end else begin
          to_cnt <= to_cnt + TO_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_word_receiver.sv
// Directed bench for uart_word_receiver with byte and word scoreboards.
module tb_uart_word_receiver;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx = 1'b1;
  logic       byte_valid;
  logic [7:0] rx_byte;
  logic       framing, overrun, partial;
  logic       clr = 1'b0;
  logic       busy;
  int         tests = 0;
  int         fails = 0;
  logic [7:0]  byte_q[$];
  logic [31:0] word_q[$];

  uart_word_receiver_if bus ();

  uart_word_receiver #(.OVERSAMPLE_DIV(4), .TIMEOUT_BITS(64)) dut (
    .iFpgaClock      (clk),
    .iCpuReset       (rst),
    .iUartRx         (rx),
    .oByteValid      (byte_valid),
    .oByte           (rx_byte),
    .word_bus        (bus.master),
    .oFramingError   (framing),
    .oOverrun        (overrun),
    .oPartialDropped (partial),
    .iClearErrors    (clr),
    .oBusy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit = 16 ticks * 4 cycles = 64 cycles.
  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    if (stop_ok) byte_q.push_back(b);
    rx = 1'b0;
    repeat (64) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (64) @(negedge clk);
    end
    rx = stop_ok;
    repeat (64) @(negedge clk);
  endtask

  task automatic pulse_ready();
    @(posedge clk); #1 bus.word_ready = 1'b1;
    @(posedge clk); #1 bus.word_ready = 1'b0;
    check("xfer_valid_low", bus.word_valid, 1'b0);
  endtask

  task automatic clear_errors();
    @(posedge clk); #1 clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst && byte_valid) begin
      check("byte_expected", byte_q.size() != 0, 1'b1);
      if (byte_q.size() != 0) check("byte_value", rx_byte, byte_q.pop_front());
    end
    if (rst && bus.word_valid && bus.word_ready) begin
      check("word_expected", word_q.size() != 0, 1'b1);
      if (word_q.size() != 0) check("word_value", bus.word, word_q.pop_front());
    end
  end

  initial begin
    bus.word_ready = 1'b0;
    // Reset and idle line
    repeat (5) @(negedge clk);
    check("rst_byte_valid", byte_valid, 1'b0);
    check("rst_byte", rx_byte, 8'h00);
    check("rst_word_valid", bus.word_valid, 1'b0);
    check("rst_word", bus.word, 32'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (2000) @(negedge clk);
    check("idle_busy", busy, 1'b0);
    check("idle_word_valid", bus.word_valid, 1'b0);
    check("idle_flags", {framing, overrun, partial}, 3'b000);

    // Four-byte word, held until ready
    send_byte(8'h78, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h12, 1'b1);
    check("w1_valid", bus.word_valid, 1'b1);
    check("w1_word", bus.word, 32'h12345678);
    repeat (100) @(negedge clk);
    check("w1_hold_valid", bus.word_valid, 1'b1);
    check("w1_hold_word", bus.word, 32'h12345678);
    word_q.push_back(32'h12345678);
    pulse_ready();

    // Short low glitch on idle line
    rx = 1'b0;
    repeat (10) @(negedge clk);
    check("glitch_busy", busy, 1'b1);
    repeat (10) @(negedge clk);
    rx = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_idle", busy, 1'b0);
    check("glitch_flags", {framing, overrun, partial}, 3'b000);

    // Framing error and break
    send_byte(8'hA5, 1'b0);
    repeat (500) @(negedge clk);
    check("fe_flag", framing, 1'b1);
    check("fe_wait_high", busy, 1'b1);
    rx = 1'b1;
    repeat (10) @(negedge clk);
    check("fe_released", busy, 1'b0);
    send_byte(8'h3C, 1'b1);
    check("fe_still_set", framing, 1'b1);
    clear_errors();
    check("fe_cleared", framing, 1'b0);
    repeat (4300) @(negedge clk);
    check("pd_after_3c", partial, 1'b1);
    clear_errors();
    check("pd_cleared", partial, 1'b0);

    // Overrun: second word arrives while first is held
    for (int i = 1; i <= 4; i++) send_byte(8'(i), 1'b1);
    check("ov_first_valid", bus.word_valid, 1'b1);
    check("ov_first_word", bus.word, 32'h04030201);
    check("ov_not_yet", overrun, 1'b0);
    for (int i = 5; i <= 8; i++) send_byte(8'(i), 1'b1);
    check("ov_flag", overrun, 1'b1);
    check("ov_word_kept", bus.word, 32'h04030201);
    word_q.push_back(32'h04030201);
    pulse_ready();
    clear_errors();
    check("ov_cleared", overrun, 1'b0);

    // Partial word timeout, then a fresh word
    send_byte(8'hEE, 1'b1);
    send_byte(8'hFF, 1'b1);
    check("pd_not_yet", partial, 1'b0);
    repeat (4300) @(negedge clk);
    check("pd_flag", partial, 1'b1);
    send_byte(8'hDD, 1'b1);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hBB, 1'b1);
    send_byte(8'hAA, 1'b1);
    check("pd_word_valid", bus.word_valid, 1'b1);
    check("pd_word", bus.word, 32'hAABBCCDD);
    word_q.push_back(32'hAABBCCDD);
    pulse_ready();

    // Reset mid-frame with one byte already in the word
    send_byte(8'h99, 1'b1);
    rx = 1'b0;
    repeat (64 + 64 * 3) @(negedge clk);
    check("mid_busy", busy, 1'b1);
    rst = 1'b0;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("mrst_busy", busy, 1'b0);
    check("mrst_byte", rx_byte, 8'h00);
    check("mrst_word_valid", bus.word_valid, 1'b0);
    check("mrst_word", bus.word, 32'h0);
    check("mrst_flags", {framing, overrun, partial}, 3'b000);
    rst = 1'b1;
    repeat (200) @(negedge clk);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    send_byte(8'h33, 1'b1);
    send_byte(8'h44, 1'b1);
    check("post_rst_valid", bus.word_valid, 1'b1);
    check("post_rst_word", bus.word, 32'h44332211);
    word_q.push_back(32'h44332211);
    pulse_ready();

    repeat (20) @(negedge clk);
    check("byte_q_drained", byte_q.size(), 0);
    check("word_q_drained", word_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
